instr_fetch: RTL and testbench

Instruction fetch stage directly upstream of `datapath` in the 4-bit CPU. It holds the program counter and a 16-entry instruction store, and presents one instruction at a time to the datapath with a valid/ready handshake. It supports PC load (`set_pc`), datapath-driven jumps and a halt opcode. A write port lets the bench or a loader fill the program store.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/instr_fetch_if.sv | 22 ++
 rtl/instr_rom.sv | 28 ++
 rtl/instr_fetch.sv | 87 ++++++++
 tb/tb_instr_fetch.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU: widths, opcodes and the fetch FSM state type.
package cpu_pkg;

  localparam int PC_W    = 4;
  localparam int INSTR_W = 8;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_NOP  = 4'h0;
  localparam opcode_t OP_LDI  = 4'h1;
  localparam opcode_t OP_ADD  = 4'h2;
  localparam opcode_t OP_SUB  = 4'h3;
  localparam opcode_t OP_JMP  = 4'h4;
  localparam opcode_t OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    HALT  = 2'd3
  } ifetch_state_t;

  function automatic opcode_t opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[7:4];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-to-datapath link: instruction handshake, next-fetch PC, redirect and halt status.
interface instr_fetch_if;
  import cpu_pkg::*;

  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic [PC_W-1:0]    pc;
  logic               jump_en;
  logic [PC_W-1:0]    jump_addr;
  logic               halted;

  modport master (
    output instr, instr_valid, pc, halted,
    input  instr_ready, jump_en, jump_addr
  );

  modport slave (
    input  instr, instr_valid, pc, halted,
    output instr_ready, jump_en, jump_addr
  );
endinterface

// File: rtl/instr_rom.sv
// Program store: 2^PC_W x INSTR_W array, synchronous write port, registered read port.
module instr_rom
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [PC_W-1:0]    waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               re,
  input  logic [PC_W-1:0]    raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [2**PC_W];

  // NOTE: the array has no reset so it maps onto plain RAM/regfile cells; only the read register is reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Same-address write during a read returns the old word: both sample pre-edge state.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, program store and valid/ready handoff to the datapath.
// Optional feature: define IFETCH_JUMP_EN to honour jump_en/jump_addr on accept cycles.
module instr_fetch
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_pc,
  input  logic [PC_W-1:0]     pc_init,
  instr_fetch_if.master       bus,
  input  logic                mem_we,
  input  logic [PC_W-1:0]     mem_waddr,
  input  logic [INSTR_W-1:0]  mem_wdata
);

  ifetch_state_t      state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               rd_en;
  logic               accept;
  logic [INSTR_W-1:0] rom_rdata;

  instr_rom u_rom (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (rd_en),
    .raddr (pc_q),
    .rdata (rom_rdata)
  );

  // The read register doubles as the instruction holding register.
  assign bus.instr       = rom_rdata;
  assign bus.instr_valid = (state_q == VALID);
  assign bus.halted      = (state_q == HALT);
  assign bus.pc          = pc_q;
  assign accept          = bus.instr_valid && bus.instr_ready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rd_en   = 1'b0;

    if (set_pc) begin
      // A restart flushes whatever is presented, even if it is being accepted.
      pc_d    = pc_init;
      state_d = FETCH;
    end else begin
      unique case (state_q)
        IDLE: ;
        FETCH: begin
          rd_en   = 1'b1;
          pc_d    = pc_q + PC_W'(1);
          state_d = VALID;
        end
        VALID: begin
          if (accept) begin
            if (opcode_of(bus.instr) == OP_HALT) begin
              state_d = HALT;
            end else begin
`ifdef IFETCH_JUMP_EN
              if (bus.jump_en) pc_d = bus.jump_addr;
`endif
              state_d = FETCH;
            end
          end
        end
        HALT: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; expectations follow IFETCH_JUMP_EN when defined.
module tb_instr_fetch;
  import cpu_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               set_pc;
  logic [PC_W-1:0]    pc_init;
  logic               mem_we;
  logic [PC_W-1:0]    mem_waddr;
  logic [INSTR_W-1:0] mem_wdata;

  int checks = 0;
  int errors = 0;

  instr_fetch_if bus ();

  instr_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .set_pc    (set_pc),
    .pc_init   (pc_init),
    .bus       (bus),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input logic [PC_W-1:0] a, input logic [INSTR_W-1:0] d);
    mem_we    = 1'b1;
    mem_waddr = a;
    mem_wdata = d;
    step();
    mem_we    = 1'b0;
  endtask

  task automatic restart(input logic [PC_W-1:0] a);
    set_pc  = 1'b1;
    pc_init = a;
    step();
    set_pc  = 1'b0;
  endtask

  task automatic expect_valid(input string tag, input logic [INSTR_W-1:0] exp_instr,
                              input logic [PC_W-1:0] exp_pc);
    check({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
    check({tag, "_instr"}, 32'(bus.instr), 32'(exp_instr));
    check({tag, "_pc"},    32'(bus.pc), 32'(exp_pc));
  endtask

  initial begin
    rst = 1'b1;  set_pc = 1'b0;  pc_init = '0;
    mem_we = 1'b0;  mem_waddr = '0;  mem_wdata = '0;
    bus.instr_ready = 1'b0;  bus.jump_en = 1'b0;  bus.jump_addr = '0;

    // Reset, then idle without set_pc
    step();
    step();
    check("rst_pc",     32'(bus.pc), 32'd0);
    check("rst_valid",  32'(bus.instr_valid), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_instr",  32'(bus.instr), 32'd0);
    rst = 1'b0;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("idle_valid", 32'(bus.instr_valid), 32'd0);
    check("idle_pc",    32'(bus.pc), 32'd0);

    // Program load
    write_mem(4'd3,  8'h12);
    write_mem(4'd4,  8'h34);
    write_mem(4'd5,  8'h56);
    write_mem(4'd6,  8'h00);
    write_mem(4'd7,  8'h3C);
    write_mem(4'd9,  8'hA7);
    write_mem(4'd15, 8'h21);
    write_mem(4'd0,  8'hF0);

    // Sequential fetch with ready held high: valid one cycle out of two
    restart(4'd3);
    check("seq_fetch_valid", 32'(bus.instr_valid), 32'd0);
    check("seq_fetch_pc",    32'(bus.pc), 32'd3);
    step();  expect_valid("seq0", 8'h12, 4'd4);
    step();  check("seq_gap0", 32'(bus.instr_valid), 32'd0);
    step();  expect_valid("seq1", 8'h34, 4'd5);
    step();  check("seq_gap1", 32'(bus.instr_valid), 32'd0);
    step();  expect_valid("seq2", 8'h56, 4'd6);

    // Backpressure: hold store[3] for 5 cycles, then release
    bus.instr_ready = 1'b0;
    restart(4'd3);
    step();  expect_valid("bp_first", 8'h12, 4'd4);
    for (int i = 0; i < 5; i++) begin
      step();
      expect_valid("bp_hold", 8'h12, 4'd4);
    end
    bus.instr_ready = 1'b1;
    step();
    check("bp_accept_valid", 32'(bus.instr_valid), 32'd0);
    check("bp_accept_pc",    32'(bus.pc), 32'd4);
    step();  expect_valid("bp_next", 8'h34, 4'd5);

    // Jump on accepting the instruction from address 4
    bus.jump_en   = 1'b1;
    bus.jump_addr = 4'd9;
    step();
    bus.jump_en   = 1'b0;
    check("jmp_accept_valid", 32'(bus.instr_valid), 32'd0);
`ifdef IFETCH_JUMP_EN
    check("jmp_pc", 32'(bus.pc), 32'd9);
    step();  expect_valid("jmp_target", 8'hA7, 4'd10);
`else
    check("jmp_pc", 32'(bus.pc), 32'd5);
    step();  expect_valid("jmp_ignored", 8'h56, 4'd6);
`endif

    // jump_en outside an accept cycle must not redirect
    bus.instr_ready = 1'b0;
    bus.jump_en     = 1'b1;
    bus.jump_addr   = 4'd2;
    restart(4'd4);
    step();  expect_valid("jmp_noaccept", 8'h34, 4'd5);
    bus.jump_en     = 1'b0;

    // Halt and PC wrap
    bus.instr_ready = 1'b1;
    restart(4'd15);
    step();  expect_valid("wrap", 8'h21, 4'd0);
    step();
    step();  expect_valid("halt_instr", 8'hF0, 4'd1);
    step();
    check("halt_halted", 32'(bus.halted), 32'd1);
    check("halt_valid",  32'(bus.instr_valid), 32'd0);
    for (int i = 0; i < 3; i++) step();
    check("halt_stay_halted", 32'(bus.halted), 32'd1);
    check("halt_stay_valid",  32'(bus.instr_valid), 32'd0);
    check("halt_stay_pc",     32'(bus.pc), 32'd1);
    restart(4'd3);
    check("resume_halted", 32'(bus.halted), 32'd0);
    check("resume_pc",     32'(bus.pc), 32'd3);
    step();  expect_valid("resume", 8'h12, 4'd4);

    // set_pc while presenting with ready high: flushed, not accepted
    restart(4'd7);
    check("flush_valid", 32'(bus.instr_valid), 32'd0);
    check("flush_pc",    32'(bus.pc), 32'd7);
    step();  expect_valid("flush_next", 8'h3C, 4'd8);

    // Write to the address being fetched returns old data; new data visible next time
    bus.instr_ready = 1'b0;
    restart(4'd7);
    write_mem(4'd7, 8'h99);
    expect_valid("wr_old", 8'h3C, 4'd8);
    restart(4'd7);
    step();  expect_valid("wr_new", 8'h99, 4'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
